// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes,
// mux select constants and the bundled control word.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Main control FSM of the multi-cycle MIPS core: one micro-step per clock,
// Moore outputs decoded from state, with mem_ready/zero gating applied combinationally.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal_op,
  output logic [3:0]          state_out
);

  // Memory handshake: mem_read/mem_write is a request held steady every cycle
  // of a memory state; the access completes in the cycle mem_ready is 1, and
  // only then does the FSM advance (and FETCH load IR / PC).

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic [5:0] op;

  assign op = 6'(opcode);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      // Opcode cannot change mid-instruction; anything else here is bogus, so refetch.
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = ALUSRCB_IMM_SH;
        ctrl.illegal_op = !is_legal_op(op);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB:  ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
    // Reset overrides in the same cycle so an aborted instruction leaves no strobe behind.
    if (!rst) ctrl = '0;
  end

  assign pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & zero);
  assign pc_source  = ctrl.pc_source;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ALUOP_W'(ctrl.alu_op);
  assign illegal_op = ctrl.illegal_op;
  assign state_out  = rst ? 4'(state) : 4'(S_FETCH);

endmodule
